// File: rtl/matrix_op_defs_pkg.sv
// Shared sizing constants for the matrix operator family and its BRAM layout.
package matrix_op_defs_pkg;
  localparam int MATRIX_DATA_WIDTH     = 32;
  localparam int MATRIX_ADDR_WIDTH     = 14;
  localparam int MATRIX_BLOCK_SIZE     = 1024;
  localparam int MATRIX_METADATA_WORDS = 3;
endpackage

// File: rtl/matrix_writer.sv
// matrix_writer: sole owner of the matrix BRAM write port. Takes one result
// matrix per request (header fields, then row-major elements) and lays it out
// in the slot chosen by matrix_id as three metadata words followed by data.
module matrix_writer #(
  parameter int DATA_WIDTH = matrix_op_defs_pkg::MATRIX_DATA_WIDTH,
  parameter int ADDR_WIDTH = matrix_op_defs_pkg::MATRIX_ADDR_WIDTH,
  parameter int BLOCK_SIZE = matrix_op_defs_pkg::MATRIX_BLOCK_SIZE,
  parameter int META_WORDS = matrix_op_defs_pkg::MATRIX_METADATA_WORDS,
  parameter int NUM_SLOTS  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  write_request,
  output logic                  write_ready,
  input  logic [2:0]            matrix_id,
  input  logic [7:0]            actual_rows,
  input  logic [7:0]            actual_cols,
  input  logic [7:0]            matrix_name [0:7],
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  writer_ready,
  output logic                  write_done,
  output logic                  write_error,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_din
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_META0  = 3'd1,
    S_META1  = 3'd2,
    S_META2  = 3'd3,
    S_STREAM = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [2:0]            r_id;
  logic [7:0]            r_rows;
  logic [7:0]            r_cols;
  logic [7:0]            r_name [0:7];
  logic [15:0]           r_count;
  logic [15:0]           r_idx;

  logic                  w_accept;
  logic [15:0]           w_req_count;
  logic                  w_id_bad;
  logic                  w_too_big;
  logic [15:0]           w_idx_next;
  logic                  w_last_beat;
  logic [ADDR_WIDTH-1:0] w_base;

  // Request qualification: element count is 8x8 -> 16 bits, so 255x255 cannot wrap.
  assign w_accept    = write_request && (r_state == S_IDLE);
  assign w_req_count = {8'h00, actual_rows} * {8'h00, actual_cols};
  assign w_id_bad    = 32'(matrix_id) >= 32'(NUM_SLOTS);
  assign w_too_big   = (32'(w_req_count) + 32'(META_WORDS)) > 32'(BLOCK_SIZE);

  // Stream bookkeeping: idx never reaches 16'hFFFF because count <= 65025.
  assign w_idx_next  = r_idx + 16'd1;
  assign w_last_beat = (w_idx_next == r_count);

  // Slot base follows the latched id so it is stable for the whole transaction.
  assign w_base = ADDR_WIDTH'(r_id) * ADDR_WIDTH'(BLOCK_SIZE);

  // Handshake and completion flags are pure decodes of the state register.
  assign write_ready  = (r_state == S_IDLE);
  assign writer_ready = (r_state == S_STREAM);
  assign write_done   = (r_state == S_DONE) || (r_state == S_ERR);
  assign write_error  = (r_state == S_ERR);

  // State register plus request latching and element index tracking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_id    <= '0;
      r_rows  <= '0;
      r_cols  <= '0;
      r_count <= '0;
      r_idx   <= '0;
      for (int i = 0; i < 8; i++) begin
        r_name[i] <= '0;
      end
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_id    <= matrix_id;
        r_rows  <= actual_rows;
        r_cols  <= actual_cols;
        r_count <= w_req_count;
        r_idx   <= '0;
        for (int i = 0; i < 8; i++) begin
          r_name[i] <= matrix_name[i];
        end
      end else if ((r_state == S_STREAM) && data_valid) begin
        r_idx <= w_idx_next;
      end
    end
  end

  // Next-state decode: header words are fixed cycles, elements wait on data_valid.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (write_request) begin
          w_next = (w_id_bad || w_too_big) ? S_ERR : S_META0;
        end
      end
      S_META0:  w_next = S_META1;
      S_META1:  w_next = S_META2;
      S_META2:  w_next = (r_count == 16'd0) ? S_DONE : S_STREAM;
      S_STREAM: begin
        if (data_valid && w_last_beat) begin
          w_next = S_DONE;
        end
      end
      S_DONE:   w_next = S_IDLE;
      S_ERR:    w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // BRAM port drive: each write is committed at the edge that ends its cycle.
  always_comb begin
    bram_we   = 1'b0;
    bram_addr = w_base;
    bram_din  = '0;
    case (r_state)
      S_META0: begin
        bram_we   = 1'b1;
        bram_addr = w_base;
        bram_din  = DATA_WIDTH'({r_rows, r_cols, 16'h0000});
      end
      S_META1: begin
        bram_we   = 1'b1;
        bram_addr = w_base + ADDR_WIDTH'(1);
        bram_din  = DATA_WIDTH'({r_name[0], r_name[1], r_name[2], r_name[3]});
      end
      S_META2: begin
        bram_we   = 1'b1;
        bram_addr = w_base + ADDR_WIDTH'(2);
        bram_din  = DATA_WIDTH'({r_name[4], r_name[5], r_name[6], r_name[7]});
      end
      S_STREAM: begin
        bram_we   = data_valid;
        bram_addr = w_base + ADDR_WIDTH'(META_WORDS) + ADDR_WIDTH'(r_idx);
        bram_din  = data_in;
      end
      default: begin
        bram_we = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_matrix_writer.sv
// Scoreboard bench for matrix_writer: stimulus queues expected BRAM writes and
// completion events; a negedge monitor pops and compares what the DUT presents.
module tb_matrix_writer;

  localparam int DW = 32;
  localparam int AW = 14;
  localparam int BS = 1024;
  localparam int MW = 3;
  localparam int NS = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          write_request;
  logic          write_ready;
  logic [2:0]    matrix_id;
  logic [7:0]    actual_rows;
  logic [7:0]    actual_cols;
  logic [7:0]    matrix_name [0:7];
  logic [DW-1:0] data_in;
  logic          data_valid;
  logic          writer_ready;
  logic          write_done;
  logic          write_error;
  logic          bram_we;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_din;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct packed {
    logic        err;
    logic [31:0] cyc;
  } done_t;

  wr_t         exp_wr [$];
  done_t       exp_done [$];
  int          n_chk = 0;
  int          n_pass = 0;
  int unsigned cyc = 0;
  int unsigned rdy_cnt = 0;
  logic        mon_en = 1'b0;
  wr_t         m_wr;
  done_t       m_done;

  matrix_writer #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .BLOCK_SIZE(BS),
    .META_WORDS(MW),
    .NUM_SLOTS (NS)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .write_request(write_request),
    .write_ready  (write_ready),
    .matrix_id    (matrix_id),
    .actual_rows  (actual_rows),
    .actual_cols  (actual_cols),
    .matrix_name  (matrix_name),
    .data_in      (data_in),
    .data_valid   (data_valid),
    .writer_ready (writer_ready),
    .write_done   (write_done),
    .write_error  (write_error),
    .bram_we      (bram_we),
    .bram_addr    (bram_addr),
    .bram_din     (bram_din)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
  endtask

  // Monitor: every BRAM write and every write_done must match the queue head.
  always @(negedge clk) begin
    if (mon_en) begin
      if (writer_ready) rdy_cnt <= rdy_cnt + 1;
      if (bram_we) begin
        if (exp_wr.size() > 0) begin
          m_wr = exp_wr.pop_front();
          chk("wr_addr", 64'(bram_addr), 64'(m_wr.addr));
          chk("wr_data", 64'(bram_din), 64'(m_wr.data));
        end else begin
          chk("spurious_write_we", 64'(bram_we), 64'd0);
        end
      end
      if (write_done) begin
        if (exp_done.size() > 0) begin
          m_done = exp_done.pop_front();
          chk("done_error", 64'(write_error), 64'(m_done.err));
          chk("done_cycle", 64'(cyc), 64'(m_done.cyc));
        end else begin
          chk("spurious_done", 64'(write_done), 64'd0);
        end
      end
    end
  end

  task automatic push_hdr(input logic [AW-1:0] base, input logic [DW-1:0] w0,
                          input logic [DW-1:0] w1, input logic [DW-1:0] w2);
    wr_t w;
    w.addr = base;                 w.data = w0; exp_wr.push_back(w);
    w.addr = base + AW'(1);        w.data = w1; exp_wr.push_back(w);
    w.addr = base + AW'(2);        w.data = w2; exp_wr.push_back(w);
  endtask

  task automatic push_done(input logic err, input int unsigned c);
    done_t d;
    d.err = err;
    d.cyc = c;
    exp_done.push_back(d);
  endtask

  // Called just after a posedge; returns the edge number at which the request was taken.
  task automatic do_req(input logic [2:0] id, input logic [7:0] r, input logic [7:0] c,
                        input logic [63:0] nm, input bit hold, output int unsigned acc);
    logic [63:0] t;
    matrix_id   = id;
    actual_rows = r;
    actual_cols = c;
    for (int i = 0; i < 8; i++) begin
      t = nm << (8 * i);
      matrix_name[i[2:0]] = t[63:56];
    end
    write_request = 1'b1;
    acc = 0;
    for (int k = 0; k < 100; k++) begin
      if (write_ready) begin
        @(posedge clk); #1;
        acc = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    if (acc == 0) chk("accept_timeout", 64'(write_ready), 64'd1);
    if (!hold) write_request = 1'b0;
  endtask

  // Sends n elements starting at v0; pat bits gate data_valid in STREAM cycles.
  task automatic do_stream(input logic [AW-1:0] base, input int n, input logic [DW-1:0] v0,
                           input logic [15:0] pat, input int plen);
    int   i;
    int   p;
    logic rdy;
    logic dv;
    wr_t  w;
    i = 0;
    p = 0;
    for (int k = 0; k < 300; k++) begin
      if (i >= n) break;
      rdy = writer_ready;
      if (rdy) begin
        dv = (p < plen) ? pat[p[3:0]] : 1'b1;
        p++;
      end else begin
        dv = 1'b1;
      end
      data_valid = dv;
      data_in    = v0 + DW'(i);
      if (rdy && dv) begin
        w.addr = base + AW'(MW) + AW'(i);
        w.data = v0 + DW'(i);
        exp_wr.push_back(w);
      end
      @(posedge clk); #1;
      if (rdy && dv) i++;
    end
    if (i < n) chk("stream_timeout", 64'(i), 64'(n));
    data_valid = 1'b0;
  endtask

  task automatic wait_quiet();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (exp_done.size() == 0 && exp_wr.size() == 0 && write_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) chk("quiet_timeout", 64'(exp_done.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required $finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned acc;
    int unsigned acc2;
    int unsigned r0;

    rst_n         = 1'b0;
    write_request = 1'b0;
    matrix_id     = '0;
    actual_rows   = '0;
    actual_cols   = '0;
    data_in       = '0;
    data_valid    = 1'b0;
    for (int i = 0; i < 8; i++) matrix_name[i[2:0]] = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_write_ready", 64'(write_ready), 64'd1);
    chk("rst_writer_ready", 64'(writer_ready), 64'd0);
    chk("rst_write_done", 64'(write_done), 64'd0);
    chk("rst_write_error", 64'(write_error), 64'd0);
    chk("rst_bram_we", 64'(bram_we), 64'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // 2x3 "A_A" to slot 1, elements 1..6 back-to-back
    push_hdr(AW'(1024), 32'h0203_0000, 32'h415F_4100, 32'h0000_0000);
    do_req(3'd1, 8'd2, 8'd3, 64'h415F_4100_0000_0000, 1'b0, acc);
    push_done(1'b0, acc + 9);
    do_stream(AW'(1024), 6, 32'd1, 16'hFFFF, 16);
    wait_quiet();

    // 2x2 with bubbles 1,0,0,1,1,0,1
    push_hdr(AW'(1024), 32'h0202_0000, 32'h415F_4100, 32'h0000_0000);
    do_req(3'd1, 8'd2, 8'd2, 64'h415F_4100_0000_0000, 1'b0, acc);
    push_done(1'b0, acc + 10);
    do_stream(AW'(1024), 4, 32'd11, 16'h0059, 7);
    wait_quiet();

    // rows=0: header only, no streaming phase
    r0 = rdy_cnt;
    push_hdr(AW'(2048), 32'h0005_0000, 32'h5A00_0000, 32'h0000_0000);
    do_req(3'd2, 8'd0, 8'd5, 64'h5A00_0000_0000_0000, 1'b0, acc);
    push_done(1'b0, acc + 3);
    wait_quiet();
    chk("t3_writer_ready_cycles", 64'(rdy_cnt - r0), 64'd0);

    // 32x32 + 3 header words exceeds the 1024-word slot: rejected
    do_req(3'd3, 8'd32, 8'd32, 64'h4F00_0000_0000_0000, 1'b0, acc);
    push_done(1'b1, acc);
    @(posedge clk); #1;
    chk("t4_write_ready_after_err", 64'(write_ready), 64'd1);
    wait_quiet();

    // 3x3 abandoned by reset after two elements, then a fresh request
    push_hdr(AW'(6144), 32'h0303_0000, 32'h4300_0000, 32'h0000_0000);
    do_req(3'd6, 8'd3, 8'd3, 64'h4300_0000_0000_0000, 1'b0, acc);
    do_stream(AW'(6144), 2, 32'h100, 16'hFFFF, 16);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("t5_write_ready", 64'(write_ready), 64'd1);
    chk("t5_writer_ready", 64'(writer_ready), 64'd0);
    chk("t5_write_done", 64'(write_done), 64'd0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    push_hdr(AW'(6144), 32'h0102_0000, 32'h4200_0000, 32'h0000_0000);
    do_req(3'd6, 8'd1, 8'd2, 64'h4200_0000_0000_0000, 1'b0, acc);
    push_done(1'b0, acc + 5);
    do_stream(AW'(6144), 2, 32'd7, 16'hFFFF, 16);
    wait_quiet();

    // write_request held high across two 1x1 transactions (slots 4 then 5)
    push_hdr(AW'(4096), 32'h0101_0000, 32'h4400_0000, 32'h0000_0000);
    do_req(3'd4, 8'd1, 8'd1, 64'h4400_0000_0000_0000, 1'b1, acc);
    push_done(1'b0, acc + 4);
    do_stream(AW'(4096), 1, 32'hAAAA, 16'hFFFF, 16);
    push_hdr(AW'(5120), 32'h0101_0000, 32'h4500_0000, 32'h0000_0000);
    do_req(3'd5, 8'd1, 8'd1, 64'h4500_0000_0000_0000, 1'b1, acc2);
    write_request = 1'b0;
    push_done(1'b0, acc2 + 4);
    chk("t6_second_accept_edge", 64'(acc2), 64'(acc + 6));
    do_stream(AW'(5120), 1, 32'hBBBB, 16'hFFFF, 16);
    wait_quiet();

    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("pending_writes", 64'(exp_wr.size()), 64'd0);
    chk("pending_dones", 64'(exp_done.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
